serial_sub: RTL

Parametrised multi-cycle subtractor: computes `a - b - bin` over `WIDTH` bits, `DIGIT` bits per clock, reusing one `DIGIT`-wide ripple-borrow full-subtractor slice. It replaces the single-bit combinational full subtractor wherever a wide difference is needed and area matters more than latency. It uses a start/busy/done handshake and holds its result registers stable between operations.

---
 rtl/serial_sub.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: a - b - bin over WIDTH bits, DIGIT bits per clock,
// reusing one DIGIT-wide ripple-borrow slice with a start/busy/done handshake.
module serial_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] workA_q;
  logic [WIDTH-1:0] workB_q;
  logic [WIDTH-1:0] workDiff_q;
  logic             borrow_q;
  logic             aSign_q;
  logic             bSign_q;
  logic [CW-1:0]    count_q;

  logic [DIGIT-1:0] digitDiff_d;
  logic             borrow_d;
  logic [WIDTH-1:0] workDiff_d;

  // One DIGIT-wide ripple-borrow slice, fed from the low end of the operands
  always_comb begin
    borrow_d    = borrow_q;
    digitDiff_d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      digitDiff_d[i] = workA_q[i] ^ workB_q[i] ^ borrow_d;
      borrow_d = (~workA_q[i] & workB_q[i]) | (~(workA_q[i] ^ workB_q[i]) & borrow_d);
    end
  end

  assign workDiff_d = (workDiff_q >> DIGIT) | (WIDTH'(digitDiff_d) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      workA_q    <= '0;
      workB_q    <= '0;
      workDiff_q <= '0;
      borrow_q   <= 1'b0;
      aSign_q    <= 1'b0;
      bSign_q    <= 1'b0;
      count_q    <= '0;
      d          <= '0;
      bout       <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            workA_q    <= a;
            workB_q    <= b;
            workDiff_q <= '0;
            borrow_q   <= bin;
            aSign_q    <= a[WIDTH-1];
            bSign_q    <= b[WIDTH-1];
            count_q    <= '0;
            busy       <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          workA_q    <= workA_q >> DIGIT;
          workB_q    <= workB_q >> DIGIT;
          workDiff_q <= workDiff_d;
          borrow_q   <= borrow_d;
          count_q    <= count_q + CW'(1);
          // Operand sign bits were saved at capture since the shifters lose them
          if (count_q == LAST) begin
            d       <= workDiff_d;
            bout    <= borrow_d;
            ovf     <= (aSign_q ^ bSign_q) & (workDiff_d[WIDTH-1] ^ aSign_q);
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
